// File: rtl/quad_byte_packer_pkg.sv
// Shared types and constants for the quad byte packer.
// Build option: QUAD_PACKER_FLUSH_EN enables post-burst drain pulses.
package quad_pkg;
  localparam int DATA_W_DEFAULT = 8;
  localparam int LANES          = 4;
  localparam int CNT_W          = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Lanes left empty when the group closes on lane index last_idx.
  function automatic logic [CNT_W-1:0] pad_for(input logic [CNT_W-1:0] last_idx);
    return CNT_W'(LANES - 1) - last_idx;
  endfunction
endpackage

// File: rtl/quad_byte_packer_if.sv
// Byte-stream input and packed-lane output bundle of the quad byte packer.
// slave: the packer itself; master: the upstream source / lane consumer.
interface quad_byte_packer_if
  import quad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_last;
  logic              o_ready;
  logic [DATA_W-1:0] o_a;
  logic [DATA_W-1:0] o_b;
  logic [DATA_W-1:0] o_c;
  logic [DATA_W-1:0] o_d;
  logic              o_enable;
  logic [CNT_W-1:0]  o_pad_cnt;
  logic              o_flush;
  logic              o_busy;

  modport slave (
    input  i_valid, i_data, i_last,
    output o_ready, o_a, o_b, o_c, o_d, o_enable, o_pad_cnt, o_flush, o_busy
  );

  modport master (
    output i_valid, i_data, i_last,
    input  o_ready, o_a, o_b, o_c, o_d, o_enable, o_pad_cnt, o_flush, o_busy
  );
endinterface

// File: rtl/quad_byte_packer_lane_sreg.sv
// Four-lane collect bank: accepted bytes land at wr_idx; on group completion
// the collected lanes (plus the completing byte) move to the output lanes,
// with lanes beyond the completing index forced to zero.
module quad_lane_sreg
  import quad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         wr_en,
  input  logic [CNT_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         load_group,
  input  logic                         load_zero,
  output logic [LANES-1:0][DATA_W-1:0] lanes
);
  logic [DATA_W-1:0] coll_reg [LANES];
  logic [DATA_W-1:0] lane_reg [LANES];

  // Capture each accepted byte into the lane chosen by the write index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LANES; i++) coll_reg[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++)
        if (wr_idx == CNT_W'(i)) coll_reg[i] <= wr_data;
    end
  end

  // Publish a group; the completing byte bypasses the collect bank, and
  // lanes past it are zero so stale bytes from earlier groups never leak.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else if (load_zero) begin
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else if (load_group) begin
      for (int i = 0; i < LANES; i++) begin
        if (CNT_W'(i) < wr_idx)       lane_reg[i] <= coll_reg[i];
        else if (CNT_W'(i) == wr_idx) lane_reg[i] <= wr_data;
        else                          lane_reg[i] <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_out
    assign lanes[gi] = lane_reg[gi];
  end
endmodule

// File: rtl/quad_byte_packer.sv
// Packs an accepted byte stream into four parallel lanes with a one-cycle
// enable per group. Build option QUAD_PACKER_FLUSH_EN appends FLUSH_CNT
// zero-lane drain pulses after each i_last group, stalling input meanwhile.
module quad_byte_packer
  import quad_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int FLUSH_CNT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  quad_byte_packer_if.slave bus
);
  localparam int                DRAIN_W    = (FLUSH_CNT < 1) ? 1 : $clog2(FLUSH_CNT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(FLUSH_CNT);

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [CNT_W-1:0]            pad_reg, pad_next;
  logic                        enable_reg, enable_next;
  logic [DRAIN_W-1:0]          drain_reg, drain_next;
  logic                        ready, accept, complete;
  logic                        load_group, load_zero;
  logic [LANES-1:0][DATA_W-1:0] lanes;

`ifdef QUAD_PACKER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
  assign ready       = (state_reg != FLUSH);
  // Drain pulses are the FLUSH-state enables after the group pulse itself.
  assign bus.o_flush = (state_reg == FLUSH) && (drain_reg != '0);
`else
  localparam bit FLUSH_ON = 1'b0;
  assign ready       = 1'b1;
  assign bus.o_flush = 1'b0;
`endif

  assign accept   = bus.i_valid & ready;
  assign complete = accept & (bus.i_last | (cnt_reg == CNT_W'(LANES - 1)));

  // State, lane counter, pulse and drain registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      pad_reg    <= '0;
      enable_reg <= 1'b0;
      drain_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pad_reg    <= pad_next;
      enable_reg <= enable_next;
      drain_reg  <= drain_next;
    end
  end

  // Next-state: group collection, completion pulse and drain sequencing.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pad_next    = pad_reg;
    enable_next = 1'b0;
    drain_next  = drain_reg;
    load_group  = 1'b0;
    load_zero   = 1'b0;
    case (state_reg)
      IDLE, COLLECT: begin
        if (complete) begin
          load_group  = 1'b1;
          enable_next = 1'b1;
          pad_next    = pad_for(cnt_reg);
          cnt_next    = '0;
          drain_next  = '0;
          state_next  = (FLUSH_ON && bus.i_last) ? FLUSH : IDLE;
        end else if (accept) begin
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = COLLECT;
        end
      end
      // Only reachable when the flush option is built in.
      FLUSH: begin
        if (drain_reg < DRAIN_LAST) begin
          load_zero   = 1'b1;
          enable_next = 1'b1;
          pad_next    = '0;
          drain_next  = drain_reg + DRAIN_W'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  quad_lane_sreg #(.DATA_W(DATA_W)) u_lane_sreg (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .wr_en      (accept),
    .wr_idx     (cnt_reg),
    .wr_data    (bus.i_data),
    .load_group (load_group),
    .load_zero  (load_zero),
    .lanes      (lanes)
  );

  assign bus.o_ready   = ready;
  assign bus.o_enable  = enable_reg;
  assign bus.o_pad_cnt = pad_reg;
  assign bus.o_busy    = (state_reg != IDLE);
  assign bus.o_a       = lanes[0];
  assign bus.o_b       = lanes[1];
  assign bus.o_c       = lanes[2];
  assign bus.o_d       = lanes[3];
endmodule

// File: tb/tb_quad_byte_packer.sv
// Directed bench for quad_byte_packer; flush scenarios are compiled in when
// QUAD_PACKER_FLUSH_EN is defined.
module tb_quad_byte_packer;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  quad_byte_packer_if #(.DATA_W(8)) bus ();

  quad_byte_packer #(.DATA_W(8), .FLUSH_CNT(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef QUAD_PACKER_FLUSH_EN
  // Downstream two-stage enable-gated adder: stage 1 sums the lanes,
  // stage 2 presents the sum.
  logic [9:0] sum_s1, sum_s2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_s1 <= '0;
      sum_s2 <= '0;
    end else if (bus.o_enable) begin
      sum_s1 <= bus.o_a + bus.o_b + bus.o_c + bus.o_d;
      sum_s2 <= sum_s1;
    end
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte, then move to the next falling edge (one rising edge later).
  task automatic send(input logic [7:0] d, input logic l);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = l;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_group(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic [1:0] pad);
    $display("group %s: a=%0d b=%0d c=%0d d=%0d pad=%0d en=%0b", tag,
             bus.o_a, bus.o_b, bus.o_c, bus.o_d, bus.o_pad_cnt, bus.o_enable);
    chk({tag, ".enable"}, bus.o_enable, 1'b1);
    chk({tag, ".a"}, bus.o_a, a);
    chk({tag, ".b"}, bus.o_b, b);
    chk({tag, ".c"}, bus.o_c, c);
    chk({tag, ".d"}, bus.o_d, d);
    chk({tag, ".pad"}, bus.o_pad_cnt, pad);
  endtask

  // Let any drain sequence following an i_last group run out.
  task automatic after_last();
`ifdef QUAD_PACKER_FLUSH_EN
    repeat (3) idle_cycle();
`else
    idle_cycle();
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst.a", bus.o_a, 8'd0);
    chk("rst.d", bus.o_d, 8'd0);
    chk("rst.enable", bus.o_enable, 1'b0);
    chk("rst.pad", bus.o_pad_cnt, 2'd0);
    chk("rst.flush", bus.o_flush, 1'b0);
    chk("rst.busy", bus.o_busy, 1'b0);
    chk("rst.ready", bus.o_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain four-byte group
    send(8'd10, 1'b0);
    chk("t1.busy1", bus.o_busy, 1'b1);
    chk("t1.noen1", bus.o_enable, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    chk("t1.ready", bus.o_ready, 1'b1);
    send(8'd40, 1'b0);
    chk_group("t1", 8'd10, 8'd20, 8'd30, 8'd40, 2'd0);
    chk("t1.busy_end", bus.o_busy, 1'b0);
    idle_cycle();
    chk("t1.pulse_one_cycle", bus.o_enable, 1'b0);
    chk("t1.hold_a", bus.o_a, 8'd10);

    // Continuous eight bytes: pulses four cycles apart
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
      if (i % 4 == 0)
        chk_group("t2", 8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i), 2'd0);
      else
        chk("t2.noen", bus.o_enable, 1'b0);
    end
    idle_cycle();

    // Short burst: two bytes, zero-padded
    send(8'd7, 1'b0);
    send(8'd9, 1'b1);
    chk_group("t3", 8'd7, 8'd9, 8'd0, 8'd0, 2'd2);
    after_last();

    // i_last on the fourth byte behaves as a normal completion
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    chk_group("t3b", 8'd1, 8'd2, 8'd3, 8'd4, 2'd0);
    after_last();

    // Single-byte burst from IDLE: three padded lanes
    send(8'hAB, 1'b1);
    chk_group("t3c", 8'hAB, 8'd0, 8'd0, 8'd0, 2'd3);
    after_last();
    chk("t3c.busy_end", bus.o_busy, 1'b0);

    // Reset in the middle of a group discards it
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    chk("t5.busy_partial", bus.o_busy, 1'b1);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("t5.rst_busy", bus.o_busy, 1'b0);
    chk("t5.rst_a", bus.o_a, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5.no_pulse", bus.o_enable, 1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    chk("t5.noen3", bus.o_enable, 1'b0);
    send(8'd4, 1'b0);
    chk_group("t5", 8'd1, 8'd2, 8'd3, 8'd4, 2'd0);
    idle_cycle();

`ifdef QUAD_PACKER_FLUSH_EN
    // Flush burst with i_valid held high through the stall
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    bus.i_data = 8'd40;
    bus.i_last = 1'b1;
    @(negedge clk);
    chk_group("f1.grp", 8'd10, 8'd20, 8'd30, 8'd40, 2'd0);
    chk("f1.grp_flush", bus.o_flush, 1'b0);
    chk("f1.grp_ready", bus.o_ready, 1'b0);
    chk("f1.grp_busy", bus.o_busy, 1'b1);
    bus.i_data = 8'd99;
    bus.i_last = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      chk_group("f1.drain", 8'd0, 8'd0, 8'd0, 8'd0, 2'd0);
      chk("f1.drain_flush", bus.o_flush, 1'b1);
      chk("f1.drain_ready", bus.o_ready, 1'b0);
    end
    chk("f1.sum", sum_s2, 10'd100);
    @(negedge clk);
    chk("f1.ready_back", bus.o_ready, 1'b1);
    chk("f1.en_off", bus.o_enable, 1'b0);
    chk("f1.flush_off", bus.o_flush, 1'b0);
    chk("f1.busy_off", bus.o_busy, 1'b0);
    // Byte 99 was never taken; 55 is the first byte of the next group
    send(8'd55, 1'b0);
    chk("f1.lane_a_taken", bus.o_busy, 1'b1);
    send(8'd56, 1'b0);
    send(8'd57, 1'b0);
    send(8'd58, 1'b0);
    chk_group("f1.next", 8'd55, 8'd56, 8'd57, 8'd58, 2'd0);
    idle_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/quad_byte_packer.md
# quad_byte_packer

Upstream feeder for the four-operand adder stage. Accepts a serial byte stream with a valid/ready handshake, packs every four accepted bytes into four parallel 8-bit lanes, and issues them with a one-cycle enable pulse. Optionally appends drain pulses after the end of a burst so the downstream enable-gated two-stage adder pipeline presents the final sum.

## Interface
- DATA_W, 8, lane/byte width
- FLUSH_CNT, 2, number of drain enables issued after a burst; equals downstream pipeline depth
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  byte on i_data is valid
- i_data  in  DATA_W  input byte
- i_last  in  1  qualifies the final byte of a burst; sampled only on accept
- o_ready  out  1  block can accept a byte this cycle
- o_a, o_b, o_c, o_d  out  DATA_W each  packed lanes; lane order is acceptance order a→d
- o_enable  out  1  one-cycle pulse: lanes carry a new group
- o_pad_cnt  out  2  number of zero-padded lanes in the current group (0..3)
- o_flush  out  1  high with o_enable during drain pulses
- o_busy  out  1  partial group held or drain in progress

## Operation
- Accept = i_valid & o_ready at a rising edge.
- Lane counter 0..3 selects the collect register written by each accepted byte.
- Group completes on the 4th accepted byte or on any accept with i_last=1.
- On completion edge: collect registers → o_a..o_d. Lanes not yet written are forced to 0; o_pad_cnt = 4 − bytes in group. Counter → 0. o_enable registered high for the next cycle only.
- o_a..o_d and o_pad_cnt hold between groups.
- FSM states:
  - IDLE: counter = 0.
  - COLLECT: counter 1..3.
  - FLUSH: macro builds only.
- Transitions:
  - IDLE→COLLECT on non-last accept.
  - COLLECT→IDLE on completion.
  - IDLE/COLLECT→FLUSH on an i_last completion (macro builds).
  - FLUSH→IDLE after FLUSH_CNT pulses.
- o_busy = (state ≠ IDLE).
- Reset values: all lane outputs 0, o_enable 0, o_pad_cnt 0, o_flush 0, o_busy 0, o_ready 1, state IDLE, counter 0.
- Reset mid-group or mid-flush discards all partial state; no pulse is issued for it.
- i_last on the 4th byte: o_pad_cnt = 0; otherwise identical to a normal completion.
- i_valid with o_ready low: ignored, not accepted, no side effect.

## Timing
- Sustained throughput: one byte per cycle; o_enable every 4th cycle during a continuous stream.
- Latency: completion edge k → o_enable and new lanes visible in cycle k+1.
- Without flush: o_ready is constant 1.
- With flush, for a last-group completion at edge k:
  - o_ready = 0 in cycles k+1 … k+1+FLUSH_CNT.
  - Drain pulses: o_enable = o_flush = 1, lanes = 0, o_pad_cnt = 0 in cycles k+2 … k+1+FLUSH_CNT.
  - o_ready returns to 1 in cycle k+2+FLUSH_CNT.
- o_enable never stays high for two consecutive cycles outside FLUSH.

## Configuration
- QUAD_PACKER_FLUSH_EN defined:
  - FLUSH state, drain pulses, o_ready deassertion and o_flush are all active.
- Undefined:
  - No FLUSH state; an i_last completion returns to IDLE.
  - o_flush tied 0; o_ready tied 1; FLUSH_CNT unused.

## Structure
- Package quad_pkg: DATA_W default, LANES = 4, lane-counter width, FSM state enum (IDLE, COLLECT, FLUSH).
- One sub-module: quad_lane_sreg, the 4-lane collect register bank with write index and zero-fill on group completion.
- The FSM, handshake and drain counter stay in the top module.

## Test plan
- Reset, then stream 10,20,30,40 with no i_last → o_enable pulse one cycle after the 4th accept; lanes a..d = 10,20,30,40; o_pad_cnt = 0; o_ready stays 1.
- Continuous 8 bytes 1..8 → two pulses 4 cycles apart; lanes 1,2,3,4 then 5,6,7,8.
- Bytes 7,9 with i_last on 9 → lanes 7,9,0,0; o_pad_cnt = 2.
- Flush build: 10,20,30,40 with i_last on 40 → group pulse, then 2 consecutive pulses with o_flush = 1 and lanes 0; o_ready low 3 cycles. Downstream adder o_sum = 100 after the second drain pulse.
- Assert i_rst_n low after 2 accepted bytes, then send 4 bytes 1,2,3,4 → no pulse for the partial group; next pulse lanes 1,2,3,4.
- Flush build: hold i_valid = 1 while o_ready = 0 → no byte consumed; the byte presented when o_ready returns lands in lane a.
